mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
- Multicycle RISC-V (RV32I subset) control unit.
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Drives the enable inputs of the design's enabled flip-flops: pc_write feeds the PC register, ir_write feeds the instruction/OldPC registers.
- Also drives the datapath mux selects and the ALU control.

Parameters:
- STATE_W, 4, width of the encoded state register; must be ≥4 to hold 12 states.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low (0 = in reset)
- op  in  7  opcode from instruction register (stable from DECODE until next FETCH)
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- pc_write  out  1  PC register enable
- ir_write  out  1  instruction/OldPC register enable
- reg_write  out  1  register file write enable
- mem_write  out  1  data memory write enable
- adr_src  out  1  memory address select: 0 = PC, 1 = ALU result
- result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult
- alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1 data
- alu_src_b  out  2  00 rs2 data, 01 ImmExt, 10 constant 4
- imm_src  out  2  00 I, 01 S, 10 B, 11 J
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal  out  1  high in ERROR state
- state  out  STATE_W  current state (debug)

Behaviour:
- State register
  - Async clear to FETCH on reset falling to 0.
  - Leaves reset on the first clk rise after reset = 1.
- Write-enable gating: while reset = 0, pc_write/ir_write/reg_write/mem_write are forced to 0 combinationally. Other outputs show the FETCH decode.
- Transitions (one state per cycle):
  - FETCH → DECODE.
  - DECODE, by op:
    - 0000011 / 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1101111 → JAL
    - 1100011 → BEQ
    - other → ERROR
  - MEMADR: op = 0000011 → MEMREAD; otherwise → MEMWRITE.
  - MEMREAD → MEMWB → FETCH.
  - MEMWRITE → FETCH.
  - EXECUTER, EXECUTEI, JAL → ALUWB → FETCH.
  - BEQ → FETCH.
  - ERROR: sticky until reset.
- Moore outputs; unlisted outputs are 0 (alu_op = 00):
  - FETCH: ir_write = 1, pc_update = 1, adr_src = 0, src_a = 00, src_b = 10, result_src = 10, alu_op = 00.
  - DECODE: src_a = 01, src_b = 01, alu_op = 00.
  - MEMADR: src_a = 10, src_b = 01.
  - MEMREAD: adr_src = 1, result_src = 00.
  - MEMWB: result_src = 01, reg_write = 1.
  - MEMWRITE: adr_src = 1, mem_write = 1.
  - EXECUTER: src_a = 10, src_b = 00, alu_op = 10.
  - EXECUTEI: src_a = 10, src_b = 01, alu_op = 10.
  - ALUWB: result_src = 00, reg_write = 1.
  - JAL: src_a = 01, src_b = 10, result_src = 00, pc_update = 1.
  - BEQ: src_a = 10, src_b = 00, alu_op = 01, result_src = 00, branch = 1.
  - ERROR: illegal = 1, all enables 0.
- Mealy output: pc_write = pc_update | (branch & zero), combinational on zero.
- ALU decode (combinational):
  - alu_op 00 → add; alu_op 01 → sub.
  - alu_op 10 by funct3:
    - 000 → sub if op[5] & funct7b5, else add
    - 010 → slt
    - 110 → or
    - 111 → and
    - other → add
  - alu_op 11 → add.
- imm_src from op: 0100011 → 01; 1100011 → 10; 1101111 → 11; else 00.
- Instruction latencies:
  - lw: 5 cycles
  - sw: 4 cycles
  - R/I-type: 4 cycles
  - jal: 4 cycles
  - beq: 3 cycles
- Reset mid-instruction: state returns to FETCH immediately (async); no pending write enable survives.

Decomposition:
- Package mc_ctrl_pkg:
  - state_t enum (FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, JAL, BEQ, ERROR)
  - opcode constants
  - alu_control encodings
  - alu_op encodings
- One sub-module: mc_alu_decoder (alu_op, funct3, op5, funct7b5 → alu_control).

Test Plan:
- Reset and first fetch:
  - Stimulus: hold reset = 0 for 3 clk, op = 0000011.
  - Response: state = FETCH, all enables 0. After release, FETCH cycle has ir_write = 1, pc_write = 1, src_b = 10.
- lw sequence:
  - Stimulus: op = 0000011.
  - Response: states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH. reg_write = 1 only in MEMWB with result_src = 01. adr_src = 1 in MEMREAD.
- R-type sub:
  - Stimulus: op = 0110011, funct3 = 000, funct7b5 = 1.
  - Response: alu_control = 001 in EXECUTER. reg_write = 1 in ALUWB.
  - Same with op = 0010011: alu_control = 000 (addi).
- beq taken and not taken:
  - Stimulus: op = 1100011; BEQ cycle with zero = 1, then a second run with zero = 0.
  - Response: pc_write = 1 and alu_control = 001 when zero = 1; pc_write = 0 when zero = 0. Returns to FETCH after 3 cycles.
- Illegal opcode:
  - Stimulus: op = 1111111.
  - Response: DECODE → ERROR, illegal = 1, enables 0 for 10+ cycles. Pulse reset = 0 returns to FETCH.
- Mid-op reset:
  - Stimulus: assert reset = 0 asynchronously in MEMWRITE (sw).
  - Response: mem_write drops to 0 immediately, state = FETCH.

Source files
------------

// File: rtl/mc_control_fsm_pkg.sv
// Shared types for the multicycle RV32I control unit:
// state encoding, opcodes, ALU encodings and per-state decode.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTER = 4'd6,
      EXECUTEI = 4'd7,
      ALUWB    = 4'd8,
      JAL      = 4'd9,
      BEQ      = 4'd10,
      ERROR    = 4'd11
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   typedef enum logic [1:0] {
      ALUOP_ADD = 2'b00,
      ALUOP_SUB = 2'b01,
      ALUOP_FN  = 2'b10,
      ALUOP_RSV = 2'b11
   } alu_op_t;

   typedef struct packed {
      logic       ir_write;
      logic       pc_update;
      logic       reg_write;
      logic       mem_write;
      logic       adr_src;
      logic [1:0] result_src;
      logic [1:0] src_a;
      logic [1:0] src_b;
      alu_op_t    alu_op;
      logic       branch;
      logic       illegal;
   } ctrl_t;

   function automatic state_t next_of(state_t s, logic [6:0] op);
      state_t n;
      n = ERROR;
      case (s)
         FETCH: n = DECODE;
         DECODE: begin
            case (op)
               OP_LW, OP_SW: n = MEMADR;
               OP_R:         n = EXECUTER;
               OP_I:         n = EXECUTEI;
               OP_JAL:       n = JAL;
               OP_BEQ:       n = BEQ;
               default:      n = ERROR;
            endcase
         end
         MEMADR:   n = (op == OP_LW) ? MEMREAD : MEMWRITE;
         MEMREAD:  n = MEMWB;
         MEMWB:    n = FETCH;
         MEMWRITE: n = FETCH;
         EXECUTER: n = ALUWB;
         EXECUTEI: n = ALUWB;
         JAL:      n = ALUWB;
         ALUWB:    n = FETCH;
         BEQ:      n = FETCH;
         default:  n = ERROR;
      endcase
      return n;
   endfunction

   function automatic ctrl_t ctrl_of(state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         FETCH: begin
            c.ir_write   = 1'b1;
            c.pc_update  = 1'b1;
            c.src_b      = 2'b10;
            c.result_src = 2'b10;
         end
         DECODE: begin
            c.src_a = 2'b01;
            c.src_b = 2'b01;
         end
         MEMADR: begin
            c.src_a = 2'b10;
            c.src_b = 2'b01;
         end
         MEMREAD:  c.adr_src = 1'b1;
         MEMWB: begin
            c.result_src = 2'b01;
            c.reg_write  = 1'b1;
         end
         MEMWRITE: begin
            c.adr_src   = 1'b1;
            c.mem_write = 1'b1;
         end
         EXECUTER: begin
            c.src_a  = 2'b10;
            c.alu_op = ALUOP_FN;
         end
         EXECUTEI: begin
            c.src_a  = 2'b10;
            c.src_b  = 2'b01;
            c.alu_op = ALUOP_FN;
         end
         ALUWB:    c.reg_write = 1'b1;
         JAL: begin
            c.src_a     = 2'b01;
            c.src_b     = 2'b10;
            c.pc_update = 1'b1;
         end
         BEQ: begin
            c.src_a  = 2'b10;
            c.alu_op = ALUOP_SUB;
            c.branch = 1'b1;
         end
         default:  c.illegal = 1'b1;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bus between the multicycle control unit
// (master) and the datapath it steers (slave).
interface mc_ctrl_if #(
   parameter int STATE_W = 4
);
   logic [6:0]         op;
   logic [2:0]         funct3;
   logic               funct7b5;
   logic               zero;
   logic               pc_write;
   logic               ir_write;
   logic               reg_write;
   logic               mem_write;
   logic               adr_src;
   logic [1:0]         result_src;
   logic [1:0]         alu_src_a;
   logic [1:0]         alu_src_b;
   logic [1:0]         imm_src;
   logic [2:0]         alu_control;
   logic               illegal;
   logic [STATE_W-1:0] state;

   modport master (
      input  op, funct3, funct7b5, zero,
      output pc_write, ir_write, reg_write,
      output mem_write, adr_src, result_src,
      output alu_src_a, alu_src_b, imm_src,
      output alu_control, illegal, state
   );

   modport slave (
      output op, funct3, funct7b5, zero,
      input  pc_write, ir_write, reg_write,
      input  mem_write, adr_src, result_src,
      input  alu_src_a, alu_src_b, imm_src,
      input  alu_control, illegal, state
   );
endinterface

// File: rtl/mc_control_fsm_alu_decoder.sv
// ALU control decode from alu_op and instruction
// function fields.
module mc_alu_decoder
   import mc_ctrl_pkg::*;
(
   input  alu_op_t    alu_op,
   input  logic [2:0] funct3,
   input  logic       op5,
   input  logic       funct7b5,
   output logic [2:0] alu_control
);

   // pick the ALU operation; only R-type with funct7b5 subtracts
   always_comb begin
      alu_control = ALU_ADD;
      unique case (alu_op)
         ALUOP_ADD: alu_control = ALU_ADD;
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FN: begin
            case (funct3)
               3'b000:
                  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control = ALU_SLT;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: alu_control = ALU_ADD;
            endcase
         end
         ALUOP_RSV: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I control unit: one state per cycle,
// registered Moore decode, Mealy branch term on zero.
module mc_control_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int STATE_W = 4
) (
   input  logic     clk,
   input  logic     reset,
   mc_ctrl_if.master bus
);

   state_t st;
   ctrl_t  q;

   // step the state and register the decode of the state being entered
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st <= FETCH;
         q  <= ctrl_of(FETCH);
      end else begin
         st <= next_of(st, bus.op);
         q  <= ctrl_of(next_of(st, bus.op));
      end
   end

   mc_alu_decoder u_alu_dec (
      .alu_op      (q.alu_op),
      .funct3      (bus.funct3),
      .op5         (bus.op[5]),
      .funct7b5    (bus.funct7b5),
      .alu_control (bus.alu_control)
   );

   // write enables are held off while reset is asserted
   assign bus.pc_write  = reset
                        & (q.pc_update | (q.branch & bus.zero));
   assign bus.ir_write  = reset & q.ir_write;
   assign bus.reg_write = reset & q.reg_write;
   assign bus.mem_write = reset & q.mem_write;

   assign bus.adr_src    = q.adr_src;
   assign bus.result_src = q.result_src;
   assign bus.alu_src_a  = q.src_a;
   assign bus.alu_src_b  = q.src_b;
   assign bus.illegal    = q.illegal;
   assign bus.state      = STATE_W'(st);

   assign bus.imm_src = (bus.op == OP_SW)  ? 2'b01 :
                        (bus.op == OP_BEQ) ? 2'b10 :
                        (bus.op == OP_JAL) ? 2'b11 : 2'b00;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized self-checking bench for mc_control_fsm; expected
// behaviour is modelled per instruction class and cycle index.
module tb_mc_control_fsm;
   import mc_ctrl_pkg::*;

   localparam int C_LW  = 0;
   localparam int C_SW  = 1;
   localparam int C_R   = 2;
   localparam int C_I   = 3;
   localparam int C_JAL = 4;
   localparam int C_BEQ = 5;

   logic clk;
   logic reset;
   int   tests;
   int   fails;

   mc_ctrl_if #(.STATE_W(4)) bus ();

   mc_control_fsm #(.STATE_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] op_of(int cls);
      case (cls)
         C_LW:    return 7'b0000011;
         C_SW:    return 7'b0100011;
         C_R:     return 7'b0110011;
         C_I:     return 7'b0010011;
         C_JAL:   return 7'b1101111;
         default: return 7'b1100011;
      endcase
   endfunction

   task automatic test_instr(input int cls, input logic [2:0] f3,
                             input logic f7, input logic z);
      state_t     seq[$];
      int         n;
      logic       e_pc, e_ir, e_rw, e_mw, e_as;
      logic [2:0] e_alu;
      logic [1:0] e_imm;
      case (cls)
         C_LW:  seq = '{FETCH, DECODE, MEMADR, MEMREAD, MEMWB};
         C_SW:  seq = '{FETCH, DECODE, MEMADR, MEMWRITE};
         C_R:   seq = '{FETCH, DECODE, EXECUTER, ALUWB};
         C_I:   seq = '{FETCH, DECODE, EXECUTEI, ALUWB};
         C_JAL: seq = '{FETCH, DECODE, JAL, ALUWB};
         default: seq = '{FETCH, DECODE, BEQ};
      endcase
      n = seq.size();
      bus.op = op_of(cls);
      bus.funct3 = f3;
      bus.funct7b5 = f7;
      e_imm = (cls == C_SW) ? 2'b01 : (cls == C_BEQ) ? 2'b10 :
              (cls == C_JAL) ? 2'b11 : 2'b00;
      for (int c = 0; c < n; c++) begin
         bus.zero = (cls == C_BEQ && c == 2) ? z : 1'($urandom);
         #1;
         e_ir = (c == 0);
         e_pc = (c == 0) || (cls == C_JAL && c == 2)
             || (cls == C_BEQ && c == 2 && z);
         e_rw = (c == n - 1) && (cls == C_LW || cls == C_R ||
                                 cls == C_I || cls == C_JAL);
         e_mw = (c == n - 1) && (cls == C_SW);
         e_as = (c == 3) && (cls == C_LW || cls == C_SW);
         e_alu = 3'b000;
         if (c == 2 && cls == C_BEQ) e_alu = 3'b001;
         if (c == 2 && (cls == C_R || cls == C_I)) begin
            if (f3 == 3'b000 && cls == C_R && f7) e_alu = 3'b001;
            else if (f3 == 3'b010) e_alu = 3'b101;
            else if (f3 == 3'b110) e_alu = 3'b011;
            else if (f3 == 3'b111) e_alu = 3'b010;
         end
         tests++;
         if (bus.state !== 4'(seq[c])) begin
            fails++;
            $display("FAIL state cls%0d cyc%0d: got %0d want %0d",
                     cls, c, bus.state, seq[c]);
         end
         tests++;
         if (bus.pc_write !== e_pc) begin
            fails++;
            $display("FAIL pc_write cls%0d cyc%0d: got %b want %b",
                     cls, c, bus.pc_write, e_pc);
         end
         tests++;
         if (bus.ir_write !== e_ir) begin
            fails++;
            $display("FAIL ir_write cls%0d cyc%0d: got %b want %b",
                     cls, c, bus.ir_write, e_ir);
         end
         tests++;
         if (bus.reg_write !== e_rw) begin
            fails++;
            $display("FAIL reg_write cls%0d cyc%0d: got %b want %b",
                     cls, c, bus.reg_write, e_rw);
         end
         tests++;
         if (bus.mem_write !== e_mw) begin
            fails++;
            $display("FAIL mem_write cls%0d cyc%0d: got %b want %b",
                     cls, c, bus.mem_write, e_mw);
         end
         tests++;
         if (bus.adr_src !== e_as) begin
            fails++;
            $display("FAIL adr_src cls%0d cyc%0d: got %b want %b",
                     cls, c, bus.adr_src, e_as);
         end
         tests++;
         if (bus.alu_control !== e_alu) begin
            fails++;
            $display("FAIL alu_control cls%0d cyc%0d: got %b want %b",
                     cls, c, bus.alu_control, e_alu);
         end
         tests++;
         if (bus.imm_src !== e_imm) begin
            fails++;
            $display("FAIL imm_src cls%0d cyc%0d: got %b want %b",
                     cls, c, bus.imm_src, e_imm);
         end
         if (c == 0) begin
            tests++;
            if ({bus.alu_src_b, bus.result_src} !== 4'b1010) begin
               fails++;
               $display("FAIL fetch_sel: got %b%b want 1010",
                        bus.alu_src_b, bus.result_src);
            end
         end
         if (e_rw) begin
            tests++;
            if (bus.result_src !== ((cls == C_LW) ? 2'b01 : 2'b00)) begin
               fails++;
               $display("FAIL wb_result_src cls%0d: got %b",
                        cls, bus.result_src);
            end
         end
         @(posedge clk);
         #1;
      end
      tests++;
      if (bus.state !== 4'(FETCH)) begin
         fails++;
         $display("FAIL return_fetch cls%0d: got %0d want %0d",
                  cls, bus.state, FETCH);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      bus.op = 7'b0000011;
      bus.funct3 = 3'b010;
      bus.funct7b5 = 1'b0;
      bus.zero = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (bus.state !== 4'(FETCH)) begin
         fails++;
         $display("FAIL reset_state: got %0d want %0d",
                  bus.state, FETCH);
      end
      tests++;
      if ({bus.pc_write, bus.ir_write, bus.reg_write,
           bus.mem_write} !== 4'b0000) begin
         fails++;
         $display("FAIL reset_enables: got %b%b%b%b want 0000",
                  bus.pc_write, bus.ir_write,
                  bus.reg_write, bus.mem_write);
      end
      tests++;
      if (bus.alu_src_b !== 2'b10) begin
         fails++;
         $display("FAIL reset_src_b: got %b want 10", bus.alu_src_b);
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      tests++;
      if ({bus.ir_write, bus.pc_write} !== 2'b11) begin
         fails++;
         $display("FAIL first_fetch: got %b%b want 11",
                  bus.ir_write, bus.pc_write);
      end
   endtask

   task automatic test_directed();
      test_instr(C_LW, 3'b010, 1'b0, 1'b0);
      test_instr(C_R, 3'b000, 1'b1, 1'b0);
      test_instr(C_I, 3'b000, 1'b1, 1'b0);
      test_instr(C_BEQ, 3'b000, 1'b0, 1'b1);
      test_instr(C_BEQ, 3'b000, 1'b0, 1'b0);
      test_instr(C_SW, 3'b010, 1'b0, 1'b0);
      test_instr(C_JAL, 3'b000, 1'b0, 1'b0);
   endtask

   task automatic test_illegal();
      bus.op = 7'b1111111;
      bus.zero = 1'b0;
      @(posedge clk);
      #1;
      tests++;
      if (bus.state !== 4'(DECODE)) begin
         fails++;
         $display("FAIL ill_decode: got %0d want %0d",
                  bus.state, DECODE);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 12; i++) begin
         bus.zero = 1'($urandom);
         #1;
         tests++;
         if (bus.state !== 4'(ERROR) || bus.illegal !== 1'b1) begin
            fails++;
            $display("FAIL ill_sticky cyc%0d: got %0d/%b want %0d/1",
                     i, bus.state, bus.illegal, ERROR);
         end
         tests++;
         if ({bus.pc_write, bus.ir_write, bus.reg_write,
              bus.mem_write} !== 4'b0000) begin
            fails++;
            $display("FAIL ill_enables cyc%0d: got %b%b%b%b want 0000",
                     i, bus.pc_write, bus.ir_write,
                     bus.reg_write, bus.mem_write);
         end
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      #1;
      tests++;
      if (bus.state !== 4'(FETCH) || bus.illegal !== 1'b0) begin
         fails++;
         $display("FAIL ill_reset: got %0d/%b want %0d/0",
                  bus.state, bus.illegal, FETCH);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_midop_reset();
      bus.op = 7'b0100011;
      bus.funct3 = 3'b010;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (bus.state !== 4'(MEMWRITE) || bus.mem_write !== 1'b1) begin
         fails++;
         $display("FAIL mid_memwrite: got %0d/%b want %0d/1",
                  bus.state, bus.mem_write, MEMWRITE);
      end
      #2;
      reset = 1'b0;
      #1;
      tests++;
      if (bus.state !== 4'(FETCH) || bus.mem_write !== 1'b0) begin
         fails++;
         $display("FAIL mid_reset: got %0d/%b want %0d/0",
                  bus.state, bus.mem_write, FETCH);
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      tests++;
      if (bus.ir_write !== 1'b1) begin
         fails++;
         $display("FAIL mid_refetch: got %b want 1", bus.ir_write);
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 150; k++) begin
         test_instr(int'($urandom_range(5, 0)),
                    3'($urandom), 1'($urandom), 1'($urandom));
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_directed();
      test_illegal();
      test_directed();
      test_midop_reset();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
